// File: rtl/freq_sweep_pkg.sv
// Shared types and constants for the frequency sweep sequencer.
package freq_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL,
        ST_ADVANCE
    } sweep_state_e;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    localparam int unsigned DEF_RST_WORD = 1;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable dwell down-counter; stops at zero and holds while frozen.
module sweep_dwell_timer #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               freeze,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!freeze && (cnt_q != '0)) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Steps the frequency control word from start to stop, holding each point for a
// programmable dwell; single, sawtooth and triangle sweeps with pause and abort.
module freq_sweep_ctrl
    import freq_sweep_pkg::*;
#(
    parameter int unsigned        WORD_W   = 8,
    parameter int unsigned        DWELL_W  = 16,
    parameter logic [WORD_W-1:0]  RST_WORD = WORD_W'(DEF_RST_WORD)
) (
    input  logic               clk_100kHz,
    input  logic               rst_,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic [1:0]         mode,
    input  logic [WORD_W-1:0]  start_word,
    input  logic [WORD_W-1:0]  stop_word,
    input  logic [WORD_W-1:0]  step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WORD_W-1:0]  freq_ctrl,
    output logic               busy,
    output logic               point_valid,
    output logic               done,
    output logic               cfg_err
);

    sweep_state_e       state_q, state_d;
    logic [WORD_W-1:0]  freq_q, freq_d;
    logic               dir_up_q, dir_up_d;
    logic               pv_q, pv_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic [1:0]         cfg_mode_q, cfg_mode_d;
    logic [WORD_W-1:0]  cfg_start_q, cfg_start_d;
    logic [WORD_W-1:0]  cfg_stop_q, cfg_stop_d;
    logic [WORD_W-1:0]  cfg_step_q, cfg_step_d;
    logic [DWELL_W-1:0] cfg_dwell_m1_q, cfg_dwell_m1_d;

    logic               tmr_load;
    logic               tmr_freeze;
    logic               tmr_zero;
    logic               cfg_ok;
    logic [WORD_W:0]    up_sum;
    logic [WORD_W:0]    dn_diff;
    logic [WORD_W-1:0]  up_next;
    logic [WORD_W-1:0]  dn_next;

    assign cfg_ok = (start_word != '0) && (stop_word != '0) &&
                    (start_word <= stop_word) && (mode != MODE_RSVD);

    // One extra bit on both sides so overflow/underflow shows up as a compare, not a wrap
    always_comb begin
        up_sum  = {1'b0, freq_q} + {1'b0, cfg_step_q};
        dn_diff = {1'b0, freq_q} - {1'b0, cfg_step_q};
        up_next = (up_sum > {1'b0, cfg_stop_q}) ? cfg_stop_q : up_sum[WORD_W-1:0];
        dn_next = (dn_diff[WORD_W] || (dn_diff[WORD_W-1:0] < cfg_start_q))
                  ? cfg_start_q : dn_diff[WORD_W-1:0];
    end

    always_comb begin
        state_d        = state_q;
        freq_d         = freq_q;
        dir_up_d       = dir_up_q;
        pv_d           = 1'b0;
        done_d         = 1'b0;
        cfg_err_d      = cfg_err_q;
        cfg_mode_d     = cfg_mode_q;
        cfg_start_d    = cfg_start_q;
        cfg_stop_d     = cfg_stop_q;
        cfg_step_d     = cfg_step_q;
        cfg_dwell_m1_d = cfg_dwell_m1_q;
        tmr_load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (cfg_ok) begin
                        cfg_mode_d     = mode;
                        cfg_start_d    = start_word;
                        cfg_stop_d     = stop_word;
                        cfg_step_d     = (step == '0) ? WORD_W'(1) : step;
                        cfg_dwell_m1_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                        cfg_err_d      = 1'b0;
                        dir_up_d       = 1'b1;
                        freq_d         = start_word;
                        pv_d           = 1'b1;
                        state_d        = ST_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                tmr_load = 1'b1;
                state_d  = ST_DWELL;
            end
            ST_DWELL: begin
                if (tmr_zero && !pause) begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                tmr_load = 1'b1;
                pv_d     = 1'b1;
                state_d  = ST_DWELL;
                if (dir_up_q) begin
                    if (freq_q == cfg_stop_q) begin
                        case (cfg_mode_q)
                            MODE_SINGLE: begin
                                tmr_load = 1'b0;
                                pv_d     = 1'b0;
                                done_d   = 1'b1;
                                state_d  = ST_IDLE;
                            end
                            MODE_SAW: freq_d = cfg_start_q;
                            MODE_TRI: begin
                                dir_up_d = 1'b0;
                                freq_d   = dn_next;
                            end
                            default: freq_d = cfg_start_q;
                        endcase
                    end else begin
                        freq_d = up_next;
                    end
                end else if (freq_q == cfg_start_q) begin
                    dir_up_d = 1'b1;
                    freq_d   = up_next;
                end else begin
                    freq_d = dn_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            freq_d   = freq_q;
            dir_up_d = dir_up_q;
            pv_d     = 1'b0;
            done_d   = 1'b1;
            tmr_load = 1'b0;
        end
    end

    assign tmr_freeze = (state_q != ST_DWELL) || pause;

    sweep_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk      (clk_100kHz),
        .rst_n    (rst_),
        .load     (tmr_load),
        .load_val (cfg_dwell_m1_q),
        .freeze   (tmr_freeze),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk_100kHz or negedge rst_) begin
        if (!rst_) begin
            state_q        <= ST_IDLE;
            freq_q         <= RST_WORD;
            dir_up_q       <= 1'b1;
            pv_q           <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            cfg_mode_q     <= MODE_SINGLE;
            cfg_start_q    <= '0;
            cfg_stop_q     <= '0;
            cfg_step_q     <= '0;
            cfg_dwell_m1_q <= '0;
        end else begin
            state_q        <= state_d;
            freq_q         <= freq_d;
            dir_up_q       <= dir_up_d;
            pv_q           <= pv_d;
            done_q         <= done_d;
            cfg_err_q      <= cfg_err_d;
            cfg_mode_q     <= cfg_mode_d;
            cfg_start_q    <= cfg_start_d;
            cfg_stop_q     <= cfg_stop_d;
            cfg_step_q     <= cfg_step_d;
            cfg_dwell_m1_q <= cfg_dwell_m1_d;
        end
    end

    assign freq_ctrl   = freq_q;
    assign busy        = (state_q != ST_IDLE);
    assign point_valid = pv_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Bench for freq_sweep_ctrl: sweep-list reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized sweeps.
module tb_freq_sweep_ctrl;

    logic        clk_100kHz = 1'b0;
    logic        rst_       = 1'b0;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;
    logic        pause      = 1'b0;
    logic [1:0]  mode       = '0;
    logic [7:0]  start_word = '0;
    logic [7:0]  stop_word  = '0;
    logic [7:0]  step       = '0;
    logic [15:0] dwell      = '0;
    logic [7:0]  freq_ctrl;
    logic        busy;
    logic        point_valid;
    logic        done;
    logic        cfg_err;

    freq_sweep_ctrl #(
        .WORD_W   (8),
        .DWELL_W  (16),
        .RST_WORD (8'd1)
    ) dut (
        .clk_100kHz  (clk_100kHz),
        .rst_        (rst_),
        .start       (start),
        .abort       (abort),
        .pause       (pause),
        .mode        (mode),
        .start_word  (start_word),
        .stop_word   (stop_word),
        .step        (step),
        .dwell       (dwell),
        .freq_ctrl   (freq_ctrl),
        .busy        (busy),
        .point_valid (point_valid),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk_100kHz = ~clk_100kHz;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the sweep is a precomputed list of points; the model
    // walks that list, holding each point for a number of cycles.
    bit m_active = 0;
    int m_freq   = 1;
    int m_pv     = 0;
    int m_done   = 0;
    int m_err    = 0;
    int m_mode, m_d, m_k, m_r;
    bit m_first;
    int up_q[$];
    int per_q[$];

    task automatic build(input int s, input int e, input int st, input int dw, input int m);
        int v;
        up_q.delete();
        per_q.delete();
        if (st == 0) st = 1;
        m_d    = (dw == 0) ? 1 : dw;
        m_mode = m;
        v = s;
        up_q.push_back(v);
        while (v != e) begin
            v = (v + st > e) ? e : v + st;
            up_q.push_back(v);
        end
        if (m == 2) begin
            for (int i = 1; i < up_q.size(); i++) per_q.push_back(up_q[i]);
            v = e;
            do begin
                v = (v - st < s) ? s : v - st;
                per_q.push_back(v);
            end while (v != s);
        end
    endtask

    function automatic int pt(input int k);
        if (m_mode == 2 && k > 0) return per_q[(k - 1) % per_q.size()];
        return up_q[k % up_q.size()];
    endfunction

    task automatic model_step();
        bit frozen;
        m_pv   = 0;
        m_done = 0;
        if (!m_active) begin
            if (start && !abort) begin
                if (start_word != 0 && stop_word != 0 && start_word <= stop_word && mode != 3) begin
                    build(start_word, stop_word, step, dwell, mode);
                    m_active = 1;
                    m_k      = 0;
                    m_freq   = pt(0);
                    m_pv     = 1;
                    m_r      = m_d + 2;
                    m_first  = 1;
                    m_err    = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else if (abort) begin
            m_active = 0;
            m_done   = 1;
        end else begin
            // the first cycle of the first point and the last cycle of any point ignore pause
            frozen = pause && (m_r != 1) && !(m_first && m_r == m_d + 2);
            if (!frozen) m_r--;
            if (m_r == 0) begin
                if (m_mode == 0 && m_k == up_q.size() - 1) begin
                    m_active = 0;
                    m_done   = 1;
                end else begin
                    m_k++;
                    m_freq  = pt(m_k);
                    m_pv    = 1;
                    m_r     = m_d + 1;
                    m_first = 0;
                end
            end
        end
    endtask

    always @(posedge clk_100kHz) begin
        cyc++;
        if (!rst_) begin
            m_active = 0;
            m_freq   = 1;
            m_pv     = 0;
            m_done   = 0;
            m_err    = 0;
        end else begin
            model_step();
        end
    end

    int dut_pts[$];
    int dut_cyc[$];
    int done_cnt = 0;

    always @(posedge clk_100kHz) begin
        #1;
        chk("freq_ctrl", freq_ctrl, m_freq);
        chk("busy", busy, m_active);
        chk("point_valid", point_valid, m_pv);
        chk("done", done, m_done);
        chk("cfg_err", cfg_err, m_err);
        if (point_valid) begin
            dut_pts.push_back(freq_ctrl);
            dut_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_100kHz);
    endtask

    task automatic do_start(input int m, input int s, input int e, input int st, input int dw);
        @(negedge clk_100kHz);
        dut_pts.delete();
        dut_cyc.delete();
        done_cnt   = 0;
        mode       = 2'(m);
        start_word = 8'(s);
        stop_word  = 8'(e);
        step       = 8'(st);
        dwell      = 16'(dw);
        start      = 1'b1;
        @(negedge clk_100kHz);
        start      = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk_100kHz);
        abort = 1'b1;
        @(negedge clk_100kHz);
        abort = 1'b0;
    endtask

    initial begin
        int exp2[7];
        int exp3[4];
        exp2 = '{5, 7, 8, 6, 5, 7, 8};
        exp3 = '{250, 255, 250, 255};

        cycles(3);
        rst_ = 1'b1;
        cycles(1);
        chk("rst_freq", freq_ctrl, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pv", point_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);

        // single up sweep
        do_start(0, 10, 20, 4, 3);
        chk("t1_first_word", freq_ctrl, 10);
        cycles(25);
        chk("t1_npts", dut_pts.size(), 4);
        chk("t1_p0", dut_pts[0], 10);
        chk("t1_p1", dut_pts[1], 14);
        chk("t1_p2", dut_pts[2], 18);
        chk("t1_p3", dut_pts[3], 20);
        chk("t1_spacing", dut_cyc[2] - dut_cyc[1], 4);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_final_word", freq_ctrl, 20);
        chk("t1_busy", busy, 0);

        // triangle
        do_start(2, 5, 8, 2, 1);
        cycles(16);
        chk("t2_busy", busy, 1);
        for (int i = 0; i < 7; i++) chk("t2_point", dut_pts[i], exp2[i]);
        do_abort();

        // sawtooth at the top of the range
        do_start(1, 250, 255, 10, 0);
        cycles(10);
        for (int i = 0; i < 4; i++) chk("t3_point", dut_pts[i], exp3[i]);
        do_abort();

        // rejected configs, then a valid one clears the error
        do_start(0, 0, 20, 1, 1);
        chk("t4a_busy", busy, 0);
        chk("t4a_cfg_err", cfg_err, 1);
        do_start(0, 30, 20, 1, 1);
        chk("t4b_busy", busy, 0);
        chk("t4b_cfg_err", cfg_err, 1);
        do_start(0, 3, 3, 1, 1);
        chk("t4c_busy", busy, 1);
        chk("t4c_cfg_err", cfg_err, 0);
        cycles(5);
        chk("t4c_done_cnt", done_cnt, 1);

        // pause stretches a point, then abort
        do_start(0, 40, 100, 10, 4);
        cycles(7);
        pause = 1'b1;
        cycles(7);
        pause = 1'b0;
        cycles(6);
        abort = 1'b1;
        @(negedge clk_100kHz);
        abort = 1'b0;
        chk("t5_npts", dut_pts.size(), 3);
        chk("t5_pause_span", dut_cyc[2] - dut_cyc[1], 12);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_done", done, 1);
        chk("t5_abort_word", freq_ctrl, 60);

        // asynchronous reset in the middle of a dwell
        do_start(1, 20, 40, 5, 5);
        cycles(3);
        #2;
        rst_ = 1'b0;
        #1;
        chk("t6_freq", freq_ctrl, 1);
        chk("t6_busy", busy, 0);
        chk("t6_pv", point_valid, 0);
        chk("t6_done", done, 0);
        chk("t6_cfg_err", cfg_err, 0);
        cycles(2);
        rst_ = 1'b1;
        cycles(1);
        chk("t6_idle", busy, 0);
        do_start(0, 7, 9, 1, 2);
        chk("t6_restart_word", freq_ctrl, 7);
        chk("t6_restart_busy", busy, 1);
        cycles(15);

        // randomized sweeps; config inputs wander mid-sweep to exercise latching
        for (int it = 0; it < 40; it++) begin
            int s;
            int n;
            s = ($urandom % 16 == 0) ? 0 : $urandom_range(1, 255);
            @(negedge clk_100kHz);
            start_word = 8'(s);
            stop_word  = ($urandom % 8 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(s, 255));
            mode       = 2'($urandom_range(0, 3));
            step       = ($urandom % 6 == 0) ? 8'd0 : 8'($urandom_range(1, 80));
            dwell      = 16'($urandom_range(0, 3));
            start      = 1'b1;
            @(negedge clk_100kHz);
            start = 1'b0;
            n = $urandom_range(10, 120);
            for (int c = 0; c < n; c++) begin
                pause = ($urandom % 8 == 0);
                abort = ($urandom % 150 == 0);
                start = ($urandom % 40 == 0);
                if ($urandom % 20 == 0) begin
                    start_word = 8'($urandom_range(0, 255));
                    stop_word  = 8'($urandom_range(0, 255));
                    step       = 8'($urandom_range(0, 255));
                    dwell      = 16'($urandom_range(0, 3));
                    mode       = 2'($urandom_range(0, 3));
                end
                @(negedge clk_100kHz);
            end
            pause = 1'b0;
            start = 1'b0;
            abort = 1'b1;
            @(negedge clk_100kHz);
            abort = 1'b0;
            cycles(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/freq_sweep_ctrl.md
Name: freq_sweep_ctrl

Overview:
- Sequencer that drives the 8-bit frequency control word into the freq_calc / DDS datapath. It steps the word from a start value to a stop value in fixed increments and holds each point for a programmable number of clk_100kHz cycles.
- Supports single, repeating (sawtooth) and triangle sweeps, with pause and abort. Sits between the front-panel/config logic and freq_calc.

Parameters:
- WORD_W, 8, width of the frequency control word
- DWELL_W, 16, width of the dwell-count input
- RST_WORD, 1, freq_ctrl value after reset; 0 is never driven

Ports:
- clk_100kHz  input  1  system clock; the only clock
- rst_  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; latches config and begins a sweep (ignored while busy)
- abort  input  1  one-cycle pulse; ends the sweep immediately
- pause  input  1  level; while high, the dwell counter freezes and the word is held
- mode  input  2  0 = single up, 1 = repeat up (sawtooth), 2 = triangle repeat, 3 = reserved (treated as invalid)
- start_word  input  WORD_W  first point
- stop_word  input  WORD_W  last point
- step  input  WORD_W  increment per point; 0 is treated as 1
- dwell  input  DWELL_W  cycles per point; 0 is treated as 1
- freq_ctrl  output  WORD_W  registered word to freq_calc
- busy  output  1  high in any state other than IDLE
- point_valid  output  1  one-cycle pulse in the cycle a new freq_ctrl value first appears
- done  output  1  one-cycle pulse when a mode-0 sweep completes or an abort is taken
- cfg_err  output  1  sticky; set on a rejected start, cleared by the next accepted start

Behaviour:
- Reset (async, rst_=0) values: state=IDLE, freq_ctrl=RST_WORD, busy=0, point_valid=0, done=0, cfg_err=0, dir=up, dwell counter=0.
- FSM states: IDLE, LOAD, DWELL, ADVANCE.
- IDLE -> LOAD on start=1 if the config is valid. Valid means start_word!=0, stop_word!=0, start_word<=stop_word and mode!=3. Config is latched in that cycle.
- Invalid config at start: stay in IDLE, set cfg_err=1, freq_ctrl unchanged.
- LOAD (1 cycle): freq_ctrl<=start_word, point_valid=1, counter<=dwell_eff-1, dir=up, next state DWELL. Latency from start to the new word is 1 cycle (the word is visible the cycle after start).
- DWELL: the counter decrements each cycle with pause=0 and freezes with pause=1. At counter==0 with pause=0, go to ADVANCE. Each point is held exactly dwell_eff unpaused cycles.
- ADVANCE (computes next point; the new word is registered in the same cycle as the transition back to DWELL, so freq_ctrl changes dwell_eff+1 cycles apart when unpaused):
  - up: nxt = cur+step_eff, computed at WORD_W+1 bits; if nxt>stop, clamp to stop. Clamping applies only once: if cur==stop, the end-of-ramp rule below applies instead.
  - up, cur==stop: mode 0 -> done=1, go to IDLE, freq_ctrl holds stop. Mode 1 -> freq_ctrl<=start. Mode 2 -> dir=down and nxt = cur-step, clamped to start (no repeat of the endpoint).
  - down, cur==start (mode 2 only): dir=up, nxt = start+step, clamped to stop.
  - start_word==stop_word: a single point. Mode 0 finishes after one dwell. Modes 1 and 2 re-emit the same word with point_valid every dwell.
  - point_valid=1 whenever freq_ctrl is written (including a re-write of the same value).
- abort: from any non-IDLE state, next state is IDLE, done=1, freq_ctrl holds its current value. abort has priority over all other transitions. start and abort in the same IDLE cycle: abort wins and start is ignored.
- start while busy: ignored, and cfg_err is unaffected.
- pause during LOAD/ADVANCE: the word is still written, and pause takes effect in DWELL.
- Width rule: all arithmetic is done at WORD_W+1 bits, so 8-bit wrap-around never occurs. freq_ctrl never exceeds stop_word or goes below start_word.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package freq_sweep_pkg: state enum (IDLE/LOAD/DWELL/ADVANCE), mode constants MODE_SINGLE=0, MODE_SAW=1, MODE_TRI=2, and the default RST_WORD.
- One sub-module, sweep_dwell_timer: a loadable down-counter with freeze input and zero flag, DWELL_W wide.

Test Plan:
- Reset, then mode 0, start=10, stop=20, step=4, dwell=3 -> freq_ctrl sequence 10,14,18,20, each held 4 cycles (3 dwell cycles + 1 ADVANCE cycle). There are 4 point_valid pulses, then done pulses, busy falls, and freq_ctrl stays at 20.
- Mode 2, start=5, stop=8, step=2, dwell=1 -> sequence 5,7,8,6,5,7,8,... with no duplicated endpoints. busy stays 1.
- Mode 1, start=250, stop=255, step=10 -> sequence 250,255,250,255. No 8-bit wrap, freq_ctrl is never below 250.
- Start with start=0, then again with start=30/stop=20 -> busy stays 0 and cfg_err=1 in both cases. A following valid start clears cfg_err.
- In mid-sweep, hold pause for 7 cycles -> the point duration extends by exactly 7 cycles. Then abort -> the next cycle shows IDLE, done=1, and freq_ctrl unchanged.
- Assert rst_=0 asynchronously in mid-dwell (between clock edges) -> outputs immediately show the reset values (freq_ctrl=1). After release, the block is IDLE and a new start works.
